// File: rtl/core_switch.sv
// core_switch: sequenced hand-over between NUM_CORES tinyriscv cores and the
// shared rib master-0 (data bus) / master-1 (fetch) ports, the JTAG register
// read-back path and the over/succ test status.
//
// A select change does not re-route the bus immediately. The switch runs in
// this order: finish the active core's in-flight data access (DRAIN), hold
// every core in reset for RST_CYCLES cycles (HOLD), then release only the
// new core (RELEASE). No core sees a half-done access or a glitching reset.
//
// Optional feature: define CORE_SWITCH_TIMEOUT_EN to bound DRAIN to
// DRAIN_MAX cycles. When DRAIN times out, HOLD is forced and the sticky
// drain_to_o flag is set. Without the macro, DRAIN waits indefinitely and
// drain_to_o is tied to 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   sel_i               requested core index (asynchronous, synchronised here)
//   core_*_i            per-core buses, core k at [k*W +: W]
//   bus_*_o/bus_ready_i rib master-0 data-bus connection
//   pc_addr_o           rib master-1 fetch address
//   jtag_rdata_o        JTAG register read data of the active core
//   core_rst_o          per-core reset, 1 = held in reset
//   active_o            index of the connected core
//   busy_o              1 while a switch is in progress
//   over_o, succ_o      registered status of the active core
//   drain_to_o          sticky drain-timeout flag
module core_switch #(
    parameter int unsigned NUM_CORES  = 2,
    parameter int unsigned SEL_W      = 1,
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned DRAIN_MAX  = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic [NUM_CORES*AW-1:0] core_addr_i,
    input  logic [NUM_CORES*DW-1:0] core_wdata_i,
    input  logic [NUM_CORES-1:0]    core_req_i,
    input  logic [NUM_CORES-1:0]    core_we_i,
    input  logic [NUM_CORES*AW-1:0] core_pc_i,
    input  logic [NUM_CORES*DW-1:0] core_jtag_rdata_i,
    input  logic [NUM_CORES-1:0]    core_over_i,
    input  logic [NUM_CORES-1:0]    core_succ_i,
    output logic [AW-1:0]           bus_addr_o,
    output logic [DW-1:0]           bus_wdata_o,
    output logic                    bus_req_o,
    output logic                    bus_we_o,
    input  logic                    bus_ready_i,
    output logic [AW-1:0]           pc_addr_o,
    output logic [DW-1:0]           jtag_rdata_o,
    output logic [NUM_CORES-1:0]    core_rst_o,
    output logic [SEL_W-1:0]        active_o,
    output logic                    busy_o,
    output logic                    over_o,
    output logic                    succ_o,
    output logic                    drain_to_o
);

    localparam int unsigned HOLD_CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_CW-1:0] HOLD_LOAD = HOLD_CW'(RST_CYCLES - 1);
    localparam logic [SEL_W:0] NUM_CORES_W = (SEL_W + 1)'(NUM_CORES);

    // Reject parameter sets that cannot address every core or hold reset.
    if (NUM_CORES < 1 || (1 << SEL_W) < NUM_CORES || RST_CYCLES < 1 || DRAIN_MAX < 1)
    begin : g_bad_params
        $error("core_switch: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    state_t               state;
    logic [HOLD_CW-1:0]   hold_cnt;
    logic [SEL_W-1:0]     target;
    logic [SEL_W-1:0]     sel_q1;
    logic [SEL_W-1:0]     sel_s;

    // Unpack the flattened per-core buses for indexed selection.
    logic [AW-1:0] addr_arr  [NUM_CORES];
    logic [DW-1:0] wdata_arr [NUM_CORES];
    logic [AW-1:0] pc_arr    [NUM_CORES];
    logic [DW-1:0] jtag_arr  [NUM_CORES];

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_unpack
        assign addr_arr[k]  = core_addr_i[k*AW +: AW];
        assign wdata_arr[k] = core_wdata_i[k*DW +: DW];
        assign pc_arr[k]    = core_pc_i[k*AW +: AW];
        assign jtag_arr[k]  = core_jtag_rdata_i[k*DW +: DW];
    end

    // Data/fetch/JTAG paths follow active_o combinationally.
    assign bus_addr_o   = addr_arr[active_o];
    assign bus_wdata_o  = wdata_arr[active_o];
    assign pc_addr_o    = pc_arr[active_o];
    assign jtag_rdata_o = jtag_arr[active_o];

    logic act_req;
    logic connected;
    logic sel_valid;
    logic start_switch;
    logic drain_done;

    assign act_req      = core_req_i[active_o];
    assign connected    = (state == ST_RUN) || (state == ST_DRAIN);
    assign bus_req_o    = connected & act_req;
    assign bus_we_o     = connected & core_we_i[active_o];
    assign sel_valid    = ((SEL_W + 1)'(sel_s) < NUM_CORES_W);
    assign start_switch = (state == ST_RUN) && sel_valid && (sel_s != active_o);
    // Either nothing is outstanding or the outstanding transfer completes now.
    assign drain_done   = !act_req || bus_ready_i;

`ifdef CORE_SWITCH_TIMEOUT_EN
    localparam int unsigned DRAIN_CW = $clog2(DRAIN_MAX + 1);
    localparam logic [DRAIN_CW-1:0] DRAIN_LAST = DRAIN_CW'(DRAIN_MAX - 1);
    logic [DRAIN_CW-1:0] drain_cnt;
`else
    assign drain_to_o = 1'b0;
`endif

    // Hand-over sequencer with registered control and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_HOLD;
            hold_cnt   <= HOLD_LOAD;
            target     <= '0;
            active_o   <= '0;
            sel_q1     <= '0;
            sel_s      <= '0;
            core_rst_o <= '1;
            busy_o     <= 1'b1;
            over_o     <= 1'b0;
            succ_o     <= 1'b0;
`ifdef CORE_SWITCH_TIMEOUT_EN
            drain_cnt  <= '0;
            drain_to_o <= 1'b0;
`endif
        end else begin
            sel_q1 <= sel_i;
            sel_s  <= sel_q1;

            // Status is only meaningful while staying connected in RUN.
            if ((state == ST_RUN) && !start_switch) begin
                over_o <= core_over_i[active_o];
                succ_o <= core_succ_i[active_o];
            end else begin
                over_o <= 1'b0;
                succ_o <= 1'b0;
            end

            case (state)
                ST_RUN: begin
                    if (start_switch) begin
                        target <= sel_s;
                        busy_o <= 1'b1;
                        state  <= ST_DRAIN;
`ifdef CORE_SWITCH_TIMEOUT_EN
                        drain_cnt <= '0;
`endif
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        core_rst_o <= '1;
                        hold_cnt   <= HOLD_LOAD;
                        state      <= ST_HOLD;
                    end
`ifdef CORE_SWITCH_TIMEOUT_EN
                    else if (drain_cnt == DRAIN_LAST) begin
                        core_rst_o <= '1;
                        hold_cnt   <= HOLD_LOAD;
                        drain_to_o <= 1'b1;
                        state      <= ST_HOLD;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
`endif
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        active_o <= target;
                        state    <= ST_RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                ST_RELEASE: begin
                    core_rst_o <= ~(NUM_CORES'(1) << active_o);
                    busy_o     <= 1'b0;
                    state      <= ST_RUN;
                end
                default: state <= ST_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_core_switch.sv
// Directed bench for core_switch: a 2-core instance (RST_CYCLES=16,
// DRAIN_MAX=8) and a 3-core instance (SEL_W=2, RST_CYCLES=4) sharing clk/rst.
module tb_core_switch;

    logic        clk = 1'b0;
    logic        rst;

    // Two-core instance
    logic [0:0]  sel;
    logic [63:0] addr, wdata, pc, jtag;
    logic [1:0]  req, we, over_in, succ_in;
    logic        ready;
    logic [31:0] bus_addr, bus_wdata, pc_addr, jtag_rdata;
    logic        bus_req, bus_we;
    logic [1:0]  core_rst;
    logic [0:0]  active;
    logic        busy, over, succ, drain_to;

    // Three-core instance
    logic [1:0]  sel3;
    logic [95:0] addr3, wdata3, pc3, jtag3;
    logic [31:0] bus_addr3, bus_wdata3, pc_addr3, jtag_rdata3;
    logic        bus_req3, bus_we3;
    logic [2:0]  core_rst3;
    logic [1:0]  active3;
    logic        busy3, over3, succ3, drain_to3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    core_switch #(
        .NUM_CORES(2), .SEL_W(1), .AW(32), .DW(32), .RST_CYCLES(16), .DRAIN_MAX(8)
    ) u_dut (
        .clk(clk), .rst(rst), .sel_i(sel),
        .core_addr_i(addr), .core_wdata_i(wdata), .core_req_i(req), .core_we_i(we),
        .core_pc_i(pc), .core_jtag_rdata_i(jtag),
        .core_over_i(over_in), .core_succ_i(succ_in),
        .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_req_o(bus_req),
        .bus_we_o(bus_we), .bus_ready_i(ready), .pc_addr_o(pc_addr),
        .jtag_rdata_o(jtag_rdata), .core_rst_o(core_rst), .active_o(active),
        .busy_o(busy), .over_o(over), .succ_o(succ), .drain_to_o(drain_to)
    );

    core_switch #(
        .NUM_CORES(3), .SEL_W(2), .AW(32), .DW(32), .RST_CYCLES(4), .DRAIN_MAX(8)
    ) u_dut3 (
        .clk(clk), .rst(rst), .sel_i(sel3),
        .core_addr_i(addr3), .core_wdata_i(wdata3), .core_req_i(3'b000),
        .core_we_i(3'b000), .core_pc_i(pc3), .core_jtag_rdata_i(jtag3),
        .core_over_i(3'b000), .core_succ_i(3'b000),
        .bus_addr_o(bus_addr3), .bus_wdata_o(bus_wdata3), .bus_req_o(bus_req3),
        .bus_we_o(bus_we3), .bus_ready_i(1'b0), .pc_addr_o(pc_addr3),
        .jtag_rdata_o(jtag_rdata3), .core_rst_o(core_rst3), .active_o(active3),
        .busy_o(busy3), .over_o(over3), .succ_o(succ3), .drain_to_o(drain_to3)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        sel     = 1'b0;
        addr    = {32'h1111_B000, 32'h0000_A000};
        wdata   = {32'h6666_0001, 32'h5555_0000};
        pc      = {32'h0000_0200, 32'h0000_0100};
        jtag    = {32'hBEEF_0001, 32'hCAFE_0000};
        req     = 2'b01;
        we      = 2'b00;
        over_in = 2'b00;
        succ_in = 2'b00;
        ready   = 1'b0;
        sel3    = 2'd0;
        addr3   = {32'h2, 32'h1, 32'h0};
        wdata3  = '0;
        pc3     = '0;
        jtag3   = '0;

        // Reset state
        tick(2);
        check("rst_core_rst", 64'(core_rst), 64'h3);
        check("rst_busy",     64'(busy),     64'h1);
        check("rst_active",   64'(active),   64'h0);
        check("rst_bus_req",  64'(bus_req),  64'h0);
        check("rst_over",     64'(over),     64'h0);
        check("rst_succ",     64'(succ),     64'h0);
        check("rst_drain_to", 64'(drain_to), 64'h0);

        // Initial HOLD, release of core 0 on the 17th edge
        rst = 1'b0;
        tick(16);
        check("hold16_core_rst", 64'(core_rst), 64'h3);
        check("hold16_busy",     64'(busy),     64'h1);
        check("hold16_bus_req",  64'(bus_req),  64'h0);
        tick(1);
        check("rel_core_rst",  64'(core_rst),   64'h2);
        check("rel_busy",      64'(busy),       64'h0);
        check("rel_active",    64'(active),     64'h0);
        check("rel_bus_req",   64'(bus_req),    64'h1);
        check("rel_bus_addr",  64'(bus_addr),   64'h0000_A000);
        check("rel_bus_wdata", 64'(bus_wdata),  64'h5555_0000);
        check("rel_pc",        64'(pc_addr),    64'h0000_0100);
        check("rel_jtag",      64'(jtag_rdata), 64'hCAFE_0000);
        check("dut3_released", 64'(core_rst3),  64'h6);

        // Out-of-range select on the 3-core instance is ignored
        sel3 = 2'd3;
        tick(6);
        check("sel3_busy",     64'(busy3),     64'h0);
        check("sel3_active",   64'(active3),   64'h0);
        check("sel3_core_rst", 64'(core_rst3), 64'h6);
        sel3 = 2'd2;
        tick(3);
        check("sel2_busy",     64'(busy3),     64'h1);

        // Status flags: one-cycle latency, inactive core ignored
        over_in = 2'b01;
        succ_in = 2'b01;
        #1;
        check("over_latency", 64'(over), 64'h0);
        tick(1);
        check("over_set", 64'(over), 64'h1);
        check("succ_set", 64'(succ), 64'h1);
        over_in = 2'b10;
        succ_in = 2'b10;
        tick(1);
        check("over_inactive", 64'(over), 64'h0);
        check("succ_inactive", 64'(succ), 64'h0);
        over_in = 2'b00;
        succ_in = 2'b00;

        // Switch 0->1 while core 0 has a stalled request
        req = 2'b01;
        sel = 1'b1;
        tick(3);
        check("drain_busy",    64'(busy),    64'h1);
        check("drain_active",  64'(active),  64'h0);
        check("drain_bus_req", 64'(bus_req), 64'h1);
        tick(5);
        check("drain5_bus_req",  64'(bus_req),  64'h1);
        check("drain5_core_rst", 64'(core_rst), 64'h2);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("hold_core_rst", 64'(core_rst), 64'h3);
        check("hold_bus_req",  64'(bus_req),  64'h0);
        tick(15);
        check("hold_end_core_rst", 64'(core_rst), 64'h3);
        check("hold_end_bus_req",  64'(bus_req),  64'h0);
        check("hold_end_active",   64'(active),   64'h0);
        tick(1);
        check("release_active",   64'(active),   64'h1);
        check("release_core_rst", 64'(core_rst), 64'h3);
        tick(1);
        check("sw1_core_rst", 64'(core_rst), 64'h1);
        check("sw1_active",   64'(active),   64'h1);
        check("sw1_busy",     64'(busy),     64'h0);
        check("sw1_bus_addr", 64'(bus_addr), 64'h1111_B000);
        check("sw1_pc",       64'(pc_addr),  64'h0000_0200);
        req = 2'b10;
        we  = 2'b10;
        #1;
        check("sw1_bus_req", 64'(bus_req), 64'h1);
        check("sw1_bus_we",  64'(bus_we),  64'h1);
        req = 2'b00;
        we  = 2'b00;

        // Select toggles during HOLD: complete, then re-switch right after RELEASE
        sel = 1'b0;
        tick(3);
        check("t4_drain_busy", 64'(busy), 64'h1);
        tick(1);
        check("t4_hold_core_rst", 64'(core_rst), 64'h3);
        tick(2);
        sel = 1'b1;
        tick(13);
        check("t4_hold_busy", 64'(busy), 64'h1);
        tick(1);
        check("t4_release_active", 64'(active), 64'h0);
        tick(1);
        check("t4_run_core_rst", 64'(core_rst), 64'h2);
        check("t4_run_busy",     64'(busy),     64'h0);
        tick(1);
        check("t4_reswitch_busy",     64'(busy),     64'h1);
        check("t4_reswitch_core_rst", 64'(core_rst), 64'h2);
        tick(1);
        check("t4_rehold_core_rst", 64'(core_rst), 64'h3);
        tick(17);
        check("t4_final_core_rst", 64'(core_rst), 64'h1);
        check("t4_final_active",   64'(active),   64'h1);

        // Stuck request on the active core
        req   = 2'b10;
        ready = 1'b0;
        sel   = 1'b0;
        tick(3);
        check("t5_drain_busy", 64'(busy), 64'h1);
        tick(7);
        check("t5_drain7_to",      64'(drain_to), 64'h0);
        check("t5_drain7_bus_req", 64'(bus_req),  64'h1);
        tick(1);
`ifdef CORE_SWITCH_TIMEOUT_EN
        check("t5_to_core_rst", 64'(core_rst), 64'h3);
        check("t5_to_flag",     64'(drain_to), 64'h1);
        check("t5_to_bus_req",  64'(bus_req),  64'h0);
`else
        check("t5_wait_core_rst", 64'(core_rst), 64'h1);
        check("t5_wait_flag",     64'(drain_to), 64'h0);
        check("t5_wait_bus_req",  64'(bus_req),  64'h1);
`endif
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("t5_hold_core_rst", 64'(core_rst), 64'h3);
`ifdef CORE_SWITCH_TIMEOUT_EN
        check("t5_to_sticky", 64'(drain_to), 64'h1);
`endif

        // Reset mid-HOLD
        tick(5);
        req = 2'b11;
        rst = 1'b1;
        tick(1);
        check("midrst_core_rst", 64'(core_rst), 64'h3);
        check("midrst_busy",     64'(busy),     64'h1);
        check("midrst_active",   64'(active),   64'h0);
        check("midrst_bus_req",  64'(bus_req),  64'h0);
        check("midrst_drain_to", 64'(drain_to), 64'h0);
        check("midrst_over",     64'(over),     64'h0);
        rst = 1'b0;
        tick(16);
        check("rerel_hold_core_rst", 64'(core_rst), 64'h3);
        tick(1);
        check("rerel_core_rst", 64'(core_rst), 64'h2);
        check("rerel_busy",     64'(busy),     64'h0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
